// File: rtl/serial_rx_tx.sv
// 8N1 UART receiver and transmitter sharing one clock; CLK_PER_BIT clocks per bit.
// Define SERIAL_RX_FRAME_CHECK_EN to discard bytes with a bad stop bit and flag rx_frame_err.
module serial_rx_tx #(
  parameter int unsigned CLK_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_new_data,
  output logic       rx_frame_err,
  output logic       tx,
  input  logic [7:0] tx_data,
  input  logic       tx_new_data,
  input  logic       tx_block,
  output logic       tx_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [15:0] BIT_END  = 16'(CLK_PER_BIT - 1);
  localparam logic [15:0] HALF_END = 16'(CLK_PER_BIT / 2 - 1);

  logic        rx_meta;
  logic        rx_sync;
  logic [1:0]  rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;

  logic [1:0]  tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

`ifdef SERIAL_RX_FRAME_CHECK_EN
  logic rx_wait_high;
`else
  assign rx_frame_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state    <= ST_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_new_data <= 1'b0;
`ifdef SERIAL_RX_FRAME_CHECK_EN
      rx_frame_err <= 1'b0;
      rx_wait_high <= 1'b0;
`endif
    end else begin
      rx_new_data <= 1'b0;
`ifdef SERIAL_RX_FRAME_CHECK_EN
      rx_frame_err <= 1'b0;
`endif
      case (rx_state)
        ST_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= '0;
          if (!rx_sync) rx_state <= ST_START;
        end
        ST_START: begin
          if (rx_cnt == HALF_END) begin
            rx_cnt   <= '0;
            rx_state <= rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (rx_cnt == BIT_END) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= ST_STOP;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: begin
`ifdef SERIAL_RX_FRAME_CHECK_EN
          // After a framing error hold here until the line is idle again.
          if (rx_wait_high) begin
            if (rx_sync) begin
              rx_wait_high <= 1'b0;
              rx_state     <= ST_IDLE;
            end
          end else if (rx_cnt == BIT_END) begin
            rx_cnt <= '0;
            if (rx_sync) begin
              rx_data     <= rx_shift;
              rx_new_data <= 1'b1;
              rx_state    <= ST_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              rx_wait_high <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
`else
          if (rx_cnt == BIT_END) begin
            rx_cnt      <= '0;
            rx_data     <= rx_shift;
            rx_new_data <= 1'b1;
            rx_state    <= ST_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
`endif
        end
      endcase
    end
  end

  // The final stop-bit cycle also accepts a request so frames can abut at 10 bit times.
  always_comb begin
    tx_accept = tx_new_data && !tx_block &&
                ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && (tx_cnt == BIT_END)));
    tx_busy   = (tx_state != ST_IDLE) || tx_block;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
    end else if (tx_accept) begin
      tx_shift <= tx_data;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx       <= 1'b0;
      tx_state <= ST_START;
    end else begin
      case (tx_state)
        ST_IDLE: begin
          tx     <= 1'b1;
          tx_cnt <= '0;
        end
        ST_START: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx       <= tx_shift[0];
            tx_state <= ST_DATA;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_bit   <= tx_bit + 3'd1;
            tx_shift <= {1'b0, tx_shift[7:1]};
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= ST_STOP;
            end else begin
              tx <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: begin
          if (tx_cnt == BIT_END) begin
            tx_cnt   <= '0;
            tx_state <= ST_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx_tx.sv
// Scoreboard bench for serial_rx_tx at CLK_PER_BIT=4: queued expected bytes are
// checked by independent rx-strobe and tx-line-decoding monitors.
module tb_serial_rx_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       tx_block = 1'b0;
  logic       echo = 1'b0;
  logic       tb_tx_new = 1'b0;
  logic [7:0] tb_tx_data = 8'h00;

  logic [7:0] rx_data;
  logic       rx_new_data;
  logic       rx_frame_err;
  logic       tx;
  logic [7:0] tx_data;
  logic       tx_new_data;
  logic       tx_busy;

  assign tx_new_data = echo ? rx_new_data : tb_tx_new;
  assign tx_data     = echo ? rx_data : tb_tx_data;

  serial_rx_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_new_data(rx_new_data),
    .rx_frame_err(rx_frame_err), .tx(tx), .tx_data(tx_data), .tx_new_data(tx_new_data),
    .tx_block(tx_block), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  int         err_exp = 0;
  logic [7:0] last_rx = 8'h00;
  logic       prev_new = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=0x%0h expected=none", name, act);
  endtask

  // Receive-side monitor: every strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst) begin
      if (rx_new_data) begin
        check("rx_strobe_width", {31'd0, prev_new}, 32'd0);
        if (rx_q.size() == 0) fail_now("rx_unexpected", {24'd0, rx_data});
        else check("rx_byte", {24'd0, rx_data}, {24'd0, rx_q.pop_front()});
      end
      if (rx_frame_err) begin
        check("err_no_strobe", {31'd0, rx_new_data}, 32'd0);
        if (err_exp == 0) fail_now("rx_frame_err_unexpected", 32'd1);
        else begin
          checks++;
          err_exp--;
        end
      end
    end
    prev_new = rx_new_data;
  end

  // Transmit-side monitor: decode the serial line at bit centres.
  logic [7:0] mon_byte;
  logic       mon_ok;
  logic       mon_start;
  logic       mon_stop;
  initial begin
    forever begin
      @(negedge clk);
      if (rst && tx === 1'b0) begin
        mon_ok = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        if (!rst) mon_ok = 1'b0;
        mon_start = tx;
        for (int j = 0; j < 8; j++) begin
          repeat (CPB) @(negedge clk);
          if (!rst) mon_ok = 1'b0;
          mon_byte[j] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (!rst) mon_ok = 1'b0;
        mon_stop = tx;
        if (mon_ok) begin
          check("tx_start_bit", {31'd0, mon_start}, 32'd0);
          check("tx_stop_bit", {31'd0, mon_stop}, 32'd1);
          if (tx_q.size() == 0) fail_now("tx_unexpected", {24'd0, mon_byte});
          else check("tx_byte", {24'd0, mon_byte}, {24'd0, tx_q.pop_front()});
        end
      end
    end
  end

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      rx = b[j];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_good_rx(input logic [7:0] b);
    rx_q.push_back(b);
    last_rx = b;
    send_rx(b, 1'b1);
  endtask

  task automatic wait_tx_idle();
    int n = 0;
    while (tx_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("tx_idle_timeout", 32'(n));
  endtask

  task automatic request_tx(input logic [7:0] b);
    tb_tx_data = b;
    tb_tx_new  = 1'b1;
    @(negedge clk);
    tb_tx_new  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  int         busy_cnt;
  logic       blk_ok;
  logic [7:0] rb;

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("reset_rx_new", {31'd0, rx_new_data}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'h00);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Directed receive of 0xA5, then data must hold
    send_good_rx(8'hA5);
    repeat (20) @(negedge clk);
    check("rx_data_hold", {24'd0, rx_data}, {24'd0, last_rx});

    // Directed transmit of 0x3C with busy-length measurement
    tx_q.push_back(8'h3C);
    request_tx(8'h3C);
    busy_cnt = 0;
    while (tx_busy && busy_cnt < 100) begin
      busy_cnt++;
      @(negedge clk);
    end
    check("tx_busy_cycles", 32'(busy_cnt), 32'd40);
    repeat (5) @(negedge clk);

    // One-cycle glitch on rx must be rejected, receiver still works afterwards
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_rx_data_hold", {24'd0, rx_data}, {24'd0, last_rx});
    send_good_rx(8'h81);
    repeat (10) @(negedge clk);

    // tx_block inhibits new frames
    tx_block = 1'b1;
    request_tx(8'h77);
    blk_ok = 1'b1;
    repeat (20) begin
      if (tx !== 1'b1 || tx_busy !== 1'b1) blk_ok = 1'b0;
      @(negedge clk);
    end
    check("tx_block_hold", {31'd0, blk_ok}, 32'd1);
    tx_block = 1'b0;
    #1;
    check("tx_block_release_busy", {31'd0, tx_busy}, 32'd0);
    @(negedge clk);
    tx_q.push_back(8'h55);
    request_tx(8'h55);
    // tx_block raised mid-frame must not abort, and must hold off the next byte
    repeat (10) @(negedge clk);
    tx_block = 1'b1;
    repeat (45) @(negedge clk);
    check("tx_blocked_after_frame", {30'd0, tx_busy, tx}, 32'd3);
    tx_block = 1'b0;
    @(negedge clk);

    // Request while busy is dropped
    tx_q.push_back(8'h11);
    request_tx(8'h11);
    request_tx(8'h22);
    wait_tx_idle();
    repeat (10) @(negedge clk);

    // Stop bit sampled low
`ifdef SERIAL_RX_FRAME_CHECK_EN
    err_exp++;
    send_rx(8'h6B, 1'b0);
    repeat (20) @(negedge clk);
    check("bad_stop_rx_data_hold", {24'd0, rx_data}, {24'd0, last_rx});
`else
    rx_q.push_back(8'h6B);
    last_rx = 8'h6B;
    send_rx(8'h6B, 1'b0);
    repeat (20) @(negedge clk);
    check("bad_stop_delivered", {24'd0, rx_data}, 32'h6B);
`endif
    send_good_rx(8'hC3);
    repeat (10) @(negedge clk);

    // Randomised concurrent receive and transmit traffic
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          rb = 8'($urandom);
          send_good_rx(rb);
          repeat ($urandom_range(0, 10)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          logic [7:0] tb;
          wait_tx_idle();
          repeat ($urandom_range(0, 6)) @(negedge clk);
          tb = 8'($urandom);
          tx_q.push_back(tb);
          request_tx(tb);
        end
      end
    join
    wait_tx_idle();
    repeat (50) @(negedge clk);
    check("rand_rx_q_drained", 32'(rx_q.size()), 32'd0);
    check("rand_tx_q_drained", 32'(tx_q.size()), 32'd0);

    // Loopback echo of back-to-back frames
    echo = 1'b1;
    foreach (rx_q[i]) rx_q.delete(i);
    begin
      logic [7:0] echo_bytes [3];
      echo_bytes = '{8'h00, 8'hFF, 8'h55};
      for (int i = 0; i < 3; i++) tx_q.push_back(echo_bytes[i]);
      for (int i = 0; i < 3; i++) send_good_rx(echo_bytes[i]);
    end
    repeat (10) @(negedge clk);
    wait_tx_idle();
    repeat (10) @(negedge clk);
    echo = 1'b0;
    check("echo_tx_q_drained", 32'(tx_q.size()), 32'd0);

    // Reset in the middle of both frames
    tx_q.push_back(8'h99);
    request_tx(8'h99);
    rx = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b0;
    tx_q.delete();
    #1;
    check("midreset_tx", {31'd0, tx}, 32'd1);
    check("midreset_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("midreset_rx_data", {24'd0, rx_data}, 32'h00);
    check("midreset_rx_new", {31'd0, rx_new_data}, 32'd0);
    rx = 1'b1;
    last_rx = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    send_good_rx(8'h3A);
    tx_q.push_back(8'hE4);
    request_tx(8'hE4);
    wait_tx_idle();
    repeat (20) @(negedge clk);

    check("final_rx_q_empty", 32'(rx_q.size()), 32'd0);
    check("final_tx_q_empty", 32'(tx_q.size()), 32'd0);
    check("final_err_exp", 32'(err_exp), 32'd0);
    check("final_rx_data", {24'd0, rx_data}, {24'd0, last_rx});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_rx_tx.md
SERIAL_RX_TX -- requirements
Module: serial_rx_tx

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 434 (115200 baud at 50 MHz), meaning clk cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port rx  input  1  asynchronous serial input, idle high.
REQ-005 SHALL have port rx_data  output  8  last received byte.
REQ-006 SHALL have port rx_new_data  output  1  one-cycle strobe marking rx_data valid.
REQ-007 SHALL have port rx_frame_err  output  1  one-cycle strobe on bad stop bit (see Configuration).
REQ-008 SHALL have port tx  output  1  serial output, idle high, registered.
REQ-009 SHALL have port tx_data  input  8  byte to send, sampled on accept.
REQ-010 SHALL have port tx_new_data  input  1  send request, one cycle.
REQ-011 SHALL have port tx_block  input  1  inhibit start of new transmissions.
REQ-012 SHALL have port tx_busy  output  1  transmitter cannot accept a byte.

Function
REQ-013 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit exactly CLK_PER_BIT cycles.
REQ-014 rx SHALL pass through a 2-flop synchronizer; every receiver decision uses the synchronized value.
REQ-015 Receiver states SHALL be IDLE, START, DATA, STOP.
REQ-016 IDLE->START on synchronized rx = 0; START waits CLK_PER_BIT/2 (integer division) cycles, then samples: 0 -> DATA, 1 -> IDLE (glitch rejected, no strobe).
REQ-017 DATA SHALL sample one bit every CLK_PER_BIT cycles (bit centres), shifting into bit 7 downward so bit 0 is first received; after 8 samples -> STOP.
REQ-018 STOP SHALL wait CLK_PER_BIT cycles, sample the stop bit, update rx_data, pulse rx_new_data for exactly one cycle and return to IDLE in that same cycle.
REQ-019 rx_data SHALL hold its value until the next accepted byte.
REQ-020 Transmitter states SHALL be IDLE, START, DATA, STOP.
REQ-021 In IDLE, tx_new_data=1 with tx_block=0 SHALL latch tx_data and enter START; tx drives 0 from the next cycle.
REQ-022 tx_new_data while tx_busy=1 SHALL be ignored (byte dropped, no queuing).
REQ-023 tx_busy SHALL be 1 whenever state != IDLE or tx_block=1; tx_busy=0 only in IDLE with tx_block=0.
REQ-024 tx_block asserted mid-frame SHALL NOT abort the frame; after STOP the transmitter stays idle until tx_block=0.
REQ-025 After STOP (CLK_PER_BIT cycles of 1) the transmitter SHALL return to IDLE and accept a new byte that cycle, allowing back-to-back frames of 10*CLK_PER_BIT cycles.
REQ-026 Receiver and transmitter SHALL operate fully independently; rx_new_data/rx_data wired to tx_new_data/tx_data SHALL form a working echo.

Reset
REQ-027 rst=0 SHALL immediately force: both FSMs to IDLE, tx=1, tx_busy=tx_block, rx_data=0x00, rx_new_data=0, rx_frame_err=0, synchronizer flops=1, counters=0.
REQ-028 Reset mid-frame SHALL abandon the frame with no strobe; after release the receiver resynchronizes on the next falling edge.

Configuration
REQ-029 Macro SERIAL_RX_FRAME_CHECK_EN defined: stop bit sampled 0 SHALL discard the byte (rx_data unchanged, no rx_new_data), pulse rx_frame_err one cycle, and return to IDLE only after rx returns to 1.
REQ-030 Macro undefined: stop bit SHALL be ignored, byte always delivered with rx_new_data, rx_frame_err tied 0.

Verification (CLK_PER_BIT=4)
REQ-031 Hold rst=0 for 5 cycles -> tx=1, tx_busy=0, rx_new_data=0, rx_data=0x00.
REQ-032 Drive rx frame of 0xA5 -> single-cycle rx_new_data with rx_data=0xA5, ~38 cycles after start edge.
REQ-033 Pulse tx_new_data with tx_data=0x3C -> tx sequence 0,0,0,1,1,1,1,0,0,1, each 4 cycles; tx_busy high 40 cycles.
REQ-034 rx low for 1 cycle -> no rx_new_data, receiver back in IDLE.
REQ-035 tx_block=1 plus tx_new_data -> tx stays 1, tx_busy=1; release and re-request 0x55 -> correct frame.
REQ-036 Loopback echo of 0x00, 0xFF, 0x55 back-to-back -> identical bytes on tx; with macro, stop bit 0 -> rx_frame_err pulse, no rx_new_data.
